// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle ops finish through EXEC. MUL and DIV
// iterate WIDTH steps in ITER, using shift-add and restoring division.
// The flag bank that gets updated is chosen by the latched interruption bit.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             s_inm,
  input  logic             interruption,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             busy,
  output logic             done,
  output logic             carry,
  output logic             zero,
  output logic             carry_intr,
  output logic             zero_intr,
  output logic             overflow,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_ITER = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic             r_sinm, r_int;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_hi, r_lo;   // MUL: partial product / multiplier; DIV: remainder / quotient
  logic [CW-1:0]    r_cnt;

  // single-cycle datapath
  logic [WIDTH-1:0] w_min, w_sbt, w_diff, w_sum, w_negop, w_sc_y;
  logic             w_sc_c, w_sc_ov;

  // iteration step datapath
  logic [WIDTH:0]   w_mul_sum, w_div_sh;
  logic [WIDTH-1:0] w_mul_hi_n, w_mul_lo_n, w_div_sub, w_div_rem_n, w_div_quo_n;
  logic             w_div_ge;

  // completion values
  logic             w_fin, w_upd, w_fc, w_fz, w_fov, w_fdbz;
  logic [WIDTH-1:0] w_fy, w_fyh;

  assign busy = (r_state == S_ITER);

  // Single-cycle results computed from the latched operands
  always_comb begin
    w_min   = r_sinm ? r_b : r_a;
    w_sbt   = r_sinm ? r_a : r_b;
    w_diff  = w_min - w_sbt;
    w_sum   = r_a + r_b;
    w_negop = (r_op[0] && !r_sinm) ? r_b : r_a;
    w_sc_y  = '0;
    w_sc_ov = 1'b0;
    case (r_op[2:0])
      3'd0: w_sc_y = r_a;
      3'd1: w_sc_y = ~r_a;
      3'd2: begin
        w_sc_y  = w_sum;
        w_sc_ov = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
      end
      3'd3: begin
        w_sc_y  = w_diff;
        w_sc_ov = (w_min[WIDTH-1] != w_sbt[WIDTH-1]) && (w_diff[WIDTH-1] != w_min[WIDTH-1]);
      end
      3'd4: w_sc_y = r_a & r_b;
      3'd5: w_sc_y = r_a | r_b;
      default: begin
        w_sc_y  = '0 - w_negop;
        w_sc_ov = (w_negop == MINV);
      end
    endcase
    w_sc_c = (r_op[2:0] == 3'd3) ? (w_min < w_sbt) : w_sc_y[WIDTH-1];
  end

  // One shift-add / restoring-division step on the working registers
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_mul_hi_n  = w_mul_sum[WIDTH:1];
    w_mul_lo_n  = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    w_div_sh    = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = (w_div_sh >= {1'b0, r_b});
    w_div_sub   = w_div_sh[WIDTH-1:0] - r_b;
    w_div_rem_n = w_div_ge ? w_div_sub : w_div_sh[WIDTH-1:0];
    w_div_quo_n = {r_lo[WIDTH-2:0], w_div_ge};
  end

  // Values committed to the outputs when an operation completes
  always_comb begin
    w_fin  = (r_state == S_EXEC) || ((r_state == S_ITER) && (r_cnt == LAST));
    w_upd  = w_fin;
    w_fy   = '0;
    w_fyh  = '0;
    w_fc   = 1'b0;
    w_fz   = 1'b0;
    w_fov  = 1'b0;
    w_fdbz = 1'b0;
    if (r_state == S_ITER) begin
      if (!r_op[0]) begin
        w_fy  = w_mul_lo_n;
        w_fyh = w_mul_hi_n;
        w_fc  = |w_mul_hi_n;
        w_fov = |w_mul_hi_n;
        w_fz  = ~|{w_mul_hi_n, w_mul_lo_n};
      end else begin
        w_fy  = w_div_quo_n;
        w_fyh = w_div_rem_n;
        w_fz  = ~|w_div_quo_n;
      end
    end else if (!r_op[3]) begin
      w_fy  = w_sc_y;
      w_fc  = w_sc_c;
      w_fov = w_sc_ov;
      w_fz  = ~|w_sc_y;
    end else if (r_op[3:1] == 3'b100) begin
      // only DIV by zero reaches EXEC with this prefix
      w_fy   = '1;
      w_fyh  = r_a;
      w_fc   = 1'b1;
      w_fov  = 1'b1;
      w_fdbz = 1'b1;
    end else begin
      w_upd = 1'b0;  // reserved opcodes leave every flag alone
    end
  end

  // FSM, operand latch and iteration registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_sinm  <= 1'b0;
      r_int   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_op   <= op;
          r_sinm <= s_inm;
          r_int  <= interruption;
          r_a    <= a;
          r_b    <= b;
          r_hi   <= '0;
          r_lo   <= (op == 4'b1001) ? a : b;
          r_cnt  <= '0;
          r_state <= ((op == 4'b1000) || ((op == 4'b1001) && (b != '0))) ? S_ITER : S_EXEC;
        end
        S_EXEC: r_state <= S_IDLE;
        S_ITER: begin
          r_hi  <= r_op[0] ? w_div_rem_n : w_mul_hi_n;
          r_lo  <= r_op[0] ? w_div_quo_n : w_mul_lo_n;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result, done pulse and flag banks
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y           <= '0;
      y_hi        <= '0;
      done        <= 1'b0;
      carry       <= 1'b0;
      zero        <= 1'b0;
      carry_intr  <= 1'b0;
      zero_intr   <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= w_fin;
      if (w_fin) begin
        y    <= w_fy;
        y_hi <= w_fyh;
      end
      if (w_upd) begin
        overflow    <= w_fov;
        div_by_zero <= w_fdbz;
        if (r_int) begin
          carry_intr <= w_fc;
          zero_intr  <= w_fz;
        end else begin
          carry <= w_fc;
          zero  <= w_fz;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=16): constant vector table, hand sequences for the
// multi-cycle corners, then random ops against an arithmetic reference model.
module tb_alu_mc;
  localparam int W = 16;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, s_inm = 1'b0, interruption = 1'b0;
  logic [3:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] y, y_hi;
  logic busy, done, carry, zero, carry_intr, zero_intr, overflow, div_by_zero;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .s_inm(s_inm),
    .interruption(interruption), .a(a), .b(b), .y(y), .y_hi(y_hi),
    .busy(busy), .done(done), .carry(carry), .zero(zero),
    .carry_intr(carry_intr), .zero_intr(zero_intr),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int lat_got, busy_got;

  // model-held flag state
  logic m_c = 0, m_z = 0, m_ci = 0, m_zi = 0, m_ov = 0, m_dbz = 0;

  typedef struct {
    logic [3:0] op; logic s; logic in; logic [W-1:0] a, b;
    logic [W-1:0] y, yh; logic c, z, ov, dbz, upd; int lat;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: results straight from the arithmetic definitions
  function automatic void ref_op(input logic [3:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] z_b,
                                 output logic [W-1:0] ry, output logic [W-1:0] ryh,
                                 output logic rc, output logic rz, output logic rov,
                                 output logic rdbz, output logic rupd, output int rlat);
    int sa, sb, full;
    logic [31:0] p;
    logic [W-1:0] m, sub, ng;
    sa = int'($signed(x)); sb = int'($signed(z_b));
    ry = '0; ryh = '0; rc = 0; rz = 0; rov = 0; rdbz = 0; rupd = 1; rlat = 1;
    case (o)
      4'd0: ry = x;
      4'd1: ry = ~x;
      4'd2: begin full = sa + sb; ry = W'(x + z_b); rov = (full > 32767) || (full < -32768); end
      4'd3: begin
        m = s ? z_b : x; sub = s ? x : z_b;
        full = int'($signed(m)) - int'($signed(sub));
        ry = W'(m - sub); rov = (full > 32767) || (full < -32768);
      end
      4'd4: ry = x & z_b;
      4'd5: ry = x | z_b;
      4'd6, 4'd7: begin
        ng = (o == 4'd7 && !s) ? z_b : x;
        full = -int'($signed(ng));
        ry = W'(0 - int'(ng)); rov = (full > 32767);
      end
      4'd8: begin
        p = {16'd0, x} * {16'd0, z_b};
        ry = p[15:0]; ryh = p[31:16]; rlat = W;
        rc = (ryh != 0); rov = rc; rz = (p == 0);
      end
      4'd9: begin
        if (z_b == 0) begin ry = '1; ryh = x; rc = 1; rov = 1; rdbz = 1; rz = 0; end
        else begin ry = x / z_b; ryh = x % z_b; rz = (ry == 0); rlat = W; end
      end
      default: rupd = 0;
    endcase
    if (o <= 4'd7) begin
      rz = (ry == 0);
      rc = (o == 4'd3) ? ((s ? z_b : x) < (s ? x : z_b)) : ry[W-1];
    end
  endfunction

  task automatic model_apply(input logic in, input logic c, input logic z, input logic ov, input logic dbz, input logic upd);
    if (upd) begin
      m_ov = ov; m_dbz = dbz;
      if (in) begin m_ci = c; m_zi = z; end else begin m_c = c; m_z = z; end
    end
  endtask

  // Starts an op at the next edge, scrambles inputs (and pulses start) while it runs,
  // returns at the sample where done is high. Called #1 after a rising edge.
  task automatic do_op(input logic [3:0] o, input logic s, input logic in, input logic [W-1:0] x, input logic [W-1:0] z_b);
    op = o; s_inm = s; interruption = in; a = x; b = z_b; start = 1'b1;
    @(posedge clk); #1;
    lat_got = 0; busy_got = int'(busy);
    while (!done && lat_got < 40) begin
      start = 1'($urandom_range(0, 1)); op = 4'($urandom); s_inm = 1'($urandom);
      interruption = 1'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      lat_got++;
      busy_got += int'(busy);
    end
    start = 1'b0;
    if (!done) begin
      n_err++;
      $display("FAIL timeout: got no done within %0d cycles, required done", lat_got);
    end
  endtask

  task automatic chk_flags(input string nm);
    chk({nm, " carry"}, 32'(carry), 32'(m_c));
    chk({nm, " zero"}, 32'(zero), 32'(m_z));
    chk({nm, " carry_intr"}, 32'(carry_intr), 32'(m_ci));
    chk({nm, " zero_intr"}, 32'(zero_intr), 32'(m_zi));
    chk({nm, " overflow"}, 32'(overflow), 32'(m_ov));
    chk({nm, " div_by_zero"}, 32'(div_by_zero), 32'(m_dbz));
  endtask

  function automatic vec_t mk(logic [3:0] o, logic s, logic in, logic [W-1:0] x, logic [W-1:0] z_b,
                              logic [W-1:0] ey, logic [W-1:0] eyh, logic c, logic z, logic ov,
                              logic dbz, logic upd, int lat);
    vec_t v;
    v.op = o; v.s = s; v.in = in; v.a = x; v.b = z_b; v.y = ey; v.yh = eyh;
    v.c = c; v.z = z; v.ov = ov; v.dbz = dbz; v.upd = upd; v.lat = lat;
    return v;
  endfunction

  initial begin
    logic [W-1:0] ry, ryh;
    logic rc, rz, rov, rdbz, rupd;
    int rlat, dpat;

    //           op     s  in a        b        y        y_hi     c  z  ov dbz upd lat
    tbl.push_back(mk(4'h2, 0, 0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(4'h3, 0, 1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h3, 1, 0, 16'h0003, 16'h0005, 16'h0002, 16'h0000, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h1, 0, 0, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(4'h0, 0, 1, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h4, 0, 0, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h5, 0, 0, 16'h1234, 16'h4321, 16'h5335, 16'h0000, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h6, 0, 0, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(4'h7, 1, 0, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h7, 0, 1, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(4'h3, 0, 0, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(4'h8, 0, 0, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 1, 0, 1, 0, 1, 16));
    tbl.push_back(mk(4'h9, 0, 0, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 0, 0, 0, 0, 1, 16));
    tbl.push_back(mk(4'h9, 0, 1, 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 1, 0, 1, 1, 1, 1));
    tbl.push_back(mk(4'hC, 0, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(4'h8, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1, 0, 1, 0, 1, 16));
    tbl.push_back(mk(4'h9, 0, 0, 16'h0003, 16'h0007, 16'h0000, 16'h0003, 0, 1, 0, 0, 1, 16));
    tbl.push_back(mk(4'h8, 0, 1, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 0, 1, 0, 0, 1, 16));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset y", 32'(y), 32'h0);
    chk("reset y_hi", 32'(y_hi), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk_flags("reset");
    reset = 1'b1;

    // vector table; first op starts on the first edge with reset high
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].s, tbl[i].in, tbl[i].a, tbl[i].b);
      chk($sformatf("vec%0d latency", i), 32'(lat_got), 32'(tbl[i].lat));
      chk($sformatf("vec%0d busy cycles", i), 32'(busy_got), 32'(tbl[i].lat > 1 ? tbl[i].lat : 0));
      chk($sformatf("vec%0d y", i), 32'(y), 32'(tbl[i].y));
      chk($sformatf("vec%0d y_hi", i), 32'(y_hi), 32'(tbl[i].yh));
      if (tbl[i].upd) begin
        if (tbl[i].in) begin m_ci = tbl[i].c; m_zi = tbl[i].z; end
        else begin m_c = tbl[i].c; m_z = tbl[i].z; end
        m_ov = tbl[i].ov; m_dbz = tbl[i].dbz;
      end
      chk_flags($sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d done pulse", i), 32'(done), 32'h0);
    end

    // reset during the 5th ITER cycle of a MUL
    op = 4'h8; a = 16'h0100; b = 16'h0100; interruption = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset y", 32'(y), 32'h0);
    chk("midreset y_hi", 32'(y_hi), 32'h0);
    chk("midreset done", 32'(done), 32'h0);
    m_c = 0; m_z = 0; m_ci = 0; m_zi = 0; m_ov = 0; m_dbz = 0;
    chk_flags("midreset");
    @(posedge clk); #1; reset = 1'b1;
    do_op(4'h2, 0, 0, 16'h0001, 16'h0001);
    chk("post-reset add latency", 32'(lat_got), 32'd1);
    chk("post-reset add y", 32'(y), 32'h0002);
    model_apply(0, 0, 0, 0, 0, 1);
    chk_flags("post-reset add");

    // back-to-back: start held high, done expected on every second sample
    op = 4'h2; s_inm = 0; interruption = 0; a = 16'h0001; b = 16'h0001; start = 1'b1;
    dpat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dpat = (dpat << 1) | int'(done);
      if (done) chk($sformatf("b2b y %0d", i), 32'(y), 32'h0002);
    end
    start = 1'b0;
    chk("b2b done pattern", 32'(dpat), 32'b01010101);

    // random ops, inputs scrambled while each runs
    for (int i = 0; i < 300; i++) begin
      logic [3:0] o; logic s, in; logic [W-1:0] x, z_b;
      o = 4'($urandom); s = 1'($urandom); in = 1'($urandom);
      x = W'($urandom); z_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      ref_op(o, s, x, z_b, ry, ryh, rc, rz, rov, rdbz, rupd, rlat);
      do_op(o, s, in, x, z_b);
      model_apply(in, rc, rz, rov, rdbz, rupd);
      chk($sformatf("rnd%0d op%h latency", i, o), 32'(lat_got), 32'(rlat));
      chk($sformatf("rnd%0d op%h y", i, o), 32'(y), 32'(ry));
      chk($sformatf("rnd%0d op%h y_hi", i, o), 32'(y_hi), 32'(ryh));
      chk_flags($sformatf("rnd%0d op%h", i, o));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width (≥4).
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 op  input  4  operation code.
REQ-007 s_inm  input  1  operand-swap/select modifier, as in single-cycle ALU.
REQ-008 interruption  input  1  selects the flag bank to update.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 y  output  WIDTH  result, low word or quotient.
REQ-011 y_hi  output  WIDTH  product high word or remainder, else 0.
REQ-012 busy  output  1  high while an iterative op runs.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 carry, zero  output  1 each  normal-bank flags.
REQ-015 carry_intr, zero_intr  output  1 each  interrupt-bank flags.
REQ-016 overflow, div_by_zero  output  1 each  status of last completed op.

Function
REQ-017 States SHALL be IDLE, EXEC, ITER; start in IDLE latches a, b, op, s_inm, interruption at that edge (edge k).
REQ-018 op 0000-0111 SHALL go IDLE->EXEC->IDLE: y, y_hi=0 and flags registered at edge k+1, done high for the cycle after edge k+1.
REQ-019 Single-cycle ops: 0000 a; 0001 ~a; 0010 a+b; 0011 s_inm ? b-a : a-b; 0100 a&b; 0101 a|b; 0110 -a; 0111 s_inm ? -a : -b; all modulo 2^WIDTH.
REQ-020 Overflow for 0010/0011 SHALL be two's-complement signed overflow of the actual operation; for 0110/0111 set when negated operand = 100...0; else 0.
REQ-021 Carry SHALL be unsigned borrow (minuend < subtrahend) for 0011, else y[WIDTH-1].
REQ-022 op 1000 (MUL) SHALL be unsigned shift-add: IDLE->ITER for WIDTH cycles, {y_hi,y}=a*b at edge k+WIDTH, done high for the following cycle.
REQ-023 op 1001 (DIV) SHALL be unsigned restoring division, same WIDTH-cycle timing: y=a/b, y_hi=a%b.
REQ-024 MUL/DIV flags: carry=overflow=(y_hi!=0) for MUL; carry=overflow=0 for DIV; zero computed on {y_hi,y} for MUL, on y for DIV.
REQ-025 DIV with b=0 SHALL complete via EXEC in one cycle: y=all ones, y_hi=a, div_by_zero=1, overflow=1, carry=1, zero=0.
REQ-026 div_by_zero SHALL be 0 on every other completed op.
REQ-027 op 1010-1111 SHALL complete via EXEC: y=0, y_hi=0, done pulses, no flag register updated.
REQ-028 Latched interruption=0 SHALL update only carry/zero; =1 only carry_intr/zero_intr; the other bank holds. overflow and div_by_zero update regardless.
REQ-029 busy SHALL equal (state==ITER); start while not IDLE SHALL be ignored with no effect.
REQ-030 start SHALL be accepted in the same cycle done is high (state is IDLE).
REQ-031 Input changes during EXEC/ITER SHALL not affect the result.
REQ-032 y, y_hi, flags SHALL hold between completions; intermediate iteration values SHALL not appear on y/y_hi.
REQ-033 Iteration counter SHALL be ceil(log2(WIDTH+1)) bits, terminating exactly after WIDTH steps.

Reset
REQ-034 reset low SHALL immediately force state IDLE, y=0, y_hi=0, busy=0, done=0, all flags 0, regardless of state, including mid-ITER.
REQ-035 First start SHALL be accepted on the first rising edge with reset high.

Verification (WIDTH=16)
REQ-036 ADD a=7FFF b=0001 int=0 -> next cycle done=1, y=8000, overflow=1, carry=1, zero=0.
REQ-037 SUB s_inm=0 a=0003 b=0005 int=1 -> y=FFFE, carry_intr=1, zero_intr=0; carry/zero unchanged from prior values.
REQ-038 MUL a=0100 b=0100 -> busy 16 cycles, then done, y=0000, y_hi=0001, carry=1, overflow=1, zero=0; start pulsed during busy ignored.
REQ-039 DIV a=0064 b=0007 -> after 16 cycles y=000E, y_hi=0002; DIV a=0005 b=0000 -> done after 1 cycle, y=FFFF, y_hi=0005, div_by_zero=1.
REQ-040 Reset asserted during ITER cycle 5 of MUL -> busy=0, y=0, flags=0 at once; after release, ADD 0001+0001 -> y=0002, done next cycle.
REQ-041 Back-to-back: start held high with op=0010 -> new op accepted on each done cycle, done every second cycle.
